// File: rtl/ulight_fifo_status_capture.sv
// ulight_fifo_status_capture: synchronised status inputs with edge capture (W1C), irq mask and Avalon-MM readback
module ulight_fifo_status_capture #(
  parameter int WIDTH       = 1,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0,
  parameter int IRQ_EN      = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);
  localparam int ARM = SYNC_STAGES + 1;
  logic [WIDTH-1:0] sync_r [SYNC_STAGES];
  logic [WIDTH-1:0] sync_q, prev, mask, edgecap, edge_det, clr, edge_raw;
  logic [2:0]       arm_cnt;
  logic             armed, wr;
  logic [31:0]      data_x, mask_x, cap_x, rd_mux;
  assign sync_q = sync_r[SYNC_STAGES-1];
  assign armed  = arm_cnt == 3'(ARM);
  assign wr     = chipselect & ~write_n;
  assign irq    = (IRQ_EN != 0) && |(edgecap & mask);
  always_comb begin
    edge_raw = EDGE_TYPE == 0 ? sync_q & ~prev : EDGE_TYPE == 1 ? ~sync_q & prev : sync_q ^ prev;
    edge_det = armed ? edge_raw : '0;
    clr      = (wr && address == 2'd2) ? writedata[WIDTH-1:0] : '0;
    data_x   = '0;
    mask_x   = '0;
    cap_x    = '0;
    data_x[WIDTH-1:0] = sync_q;
    mask_x[WIDTH-1:0] = mask;
    cap_x[WIDTH-1:0]  = edgecap;
    rd_mux = address == 2'd0 ? data_x : address == 2'd1 ? mask_x : address == 2'd2 ? cap_x : '0;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_r[i] <= '0;
      prev     <= '0;
      mask     <= '0;
      edgecap  <= '0;
      arm_cnt  <= '0;
      readdata <= '0;
    end else begin
      sync_r[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
      prev <= sync_q;
      if (!armed) arm_cnt <= arm_cnt + 3'd1;
      if (IRQ_EN != 0 && wr && address == 2'd1) mask <= writedata[WIDTH-1:0];
      // OR-ing the new edge after the clear lets a same-cycle set win over W1C
      edgecap  <= (edgecap & ~clr) | edge_det;
      readdata <= rd_mux;
    end
endmodule

// File: tb/tb_ulight_fifo_status_capture.sv
// tb_ulight_fifo_status_capture: table vectors plus scoreboarded reads on an 8-bit rising-edge and a 4-bit any-edge instance
module tb_ulight_fifo_status_capture;
  logic        clk = 0, reset_n = 0, chipselect = 0, write_n = 1;
  logic [1:0]  address = 0;
  logic [31:0] writedata = 0, readdata0, readdata1;
  logic [7:0]  in8 = 8'hFF;
  logic [3:0]  in4 = 4'h0;
  logic        irq0, irq1;
  int          n_chk = 0, n_fail = 0;
  logic [31:0] sb [$];
  typedef struct {
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] e0;
    logic [31:0] e1;
    logic        eirq;
  } vec_t;
  vec_t vecs [10];

  always #5 clk = ~clk;

  ulight_fifo_status_capture #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(0), .IRQ_EN(1)) dut0 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in8), .readdata(readdata0), .irq(irq0));
  ulight_fifo_status_capture #(.WIDTH(4), .SYNC_STAGES(2), .EDGE_TYPE(2), .IRQ_EN(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in4), .readdata(readdata1), .irq(irq1));

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1; write_n = 0;
    @(posedge clk);
    #1;
    chipselect = 0; write_n = 1;
  endtask

  task automatic rd(input bit sel, input logic [1:0] a, input logic [31:0] e, input string nm);
    @(negedge clk);
    address = a;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check(nm, sel ? readdata1 : readdata0, sb.pop_front());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1, 2'd1, 32'hFFFF_FFFF, 32'h02, 32'h2, 0};
    vecs[1] = '{0, 2'd1, 32'h0,         32'hFF, 32'hF, 0};
    vecs[2] = '{1, 2'd0, 32'h1234_5678, 32'h06, 32'h0, 0};
    vecs[3] = '{0, 2'd0, 32'h0,         32'h06, 32'h0, 0};
    vecs[4] = '{1, 2'd3, 32'hFFFF_FFFF, 32'h00, 32'h0, 0};
    vecs[5] = '{0, 2'd3, 32'h0,         32'h00, 32'h0, 0};
    vecs[6] = '{1, 2'd2, 32'hFFFF_FFFF, 32'h00, 32'h0, 0};
    vecs[7] = '{0, 2'd2, 32'h0,         32'h00, 32'h0, 0};
    vecs[8] = '{1, 2'd1, 32'h0,         32'hFF, 32'hF, 0};
    vecs[9] = '{0, 2'd1, 32'h0,         32'h00, 32'h0, 0};

    cycles(2);
    check("reset_rd", readdata0, 32'h0);
    check("reset_irq", {31'b0, irq0}, 32'h0);
    @(negedge clk) reset_n = 1;
    cycles(10);
    rd(0, 2'd2, 32'h0, "static_ones_no_cap");
    check("static_ones_irq", {31'b0, irq0}, 32'h0);
    rd(0, 2'd0, 32'hFF, "data_ones");

    @(negedge clk) in8 = 8'h00;
    cycles(4);
    rd(0, 2'd2, 32'h0, "falling_ignored");
    wr(2'd1, 32'h05);
    @(negedge clk) in8 = 8'h04;
    cycles(2);
    check("irq_before_k2", {31'b0, irq0}, 32'h0);
    cycles(1);
    check("irq_at_k2", {31'b0, irq0}, 32'h1);
    rd(0, 2'd2, 32'h04, "cap_bit2");
    wr(2'd2, 32'h04);
    check("w1c_read_preclear", readdata0, 32'h04);
    check("irq_after_w1c", {31'b0, irq0}, 32'h0);
    rd(0, 2'd2, 32'h0, "cap_cleared");

    wr(2'd1, 32'h0);
    @(negedge clk) in8 = 8'h06;
    cycles(3);
    rd(0, 2'd2, 32'h02, "cap_masked");
    check("irq_masked", {31'b0, irq0}, 32'h0);
    wr(2'd1, 32'h02);
    check("irq_unmasked", {31'b0, irq0}, 32'h1);
    wr(2'd2, 32'h02);
    check("irq_cleared", {31'b0, irq0}, 32'h0);

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      address = vecs[i].addr; writedata = vecs[i].wdata;
      chipselect = vecs[i].wr; write_n = ~vecs[i].wr;
      sb.push_back(vecs[i].e0);
      sb.push_back(vecs[i].e1);
      @(posedge clk);
      #1;
      chipselect = 0; write_n = 1;
      check($sformatf("vec%0d_rd0", i), readdata0, sb.pop_front());
      check($sformatf("vec%0d_rd1", i), readdata1, sb.pop_front());
      check($sformatf("vec%0d_irq", i), {31'b0, irq0}, {31'b0, vecs[i].eirq});
    end

    @(negedge clk) in4 = 4'h1;
    cycles(2);
    @(negedge clk) in4 = 4'h0;
    cycles(6);
    rd(1, 2'd2, 32'h1, "any_edge_collapse");
    @(negedge clk) in4 = 4'h1;
    @(posedge clk);
    @(posedge clk);
    wr(2'd2, 32'h1);
    rd(1, 2'd2, 32'h1, "set_wins_over_w1c");
    wr(2'd2, 32'h1);
    rd(1, 2'd2, 32'h0, "w1c_clear_dut1");

    @(negedge clk) in8 = 8'h04;
    cycles(3);
    @(negedge clk) in8 = 8'h07;
    cycles(3);
    wr(2'd1, 32'h03);
    check("irq_pre_reset", {31'b0, irq0}, 32'h1);
    rd(0, 2'd2, 32'h03, "cap_pre_reset");
    @(negedge clk);
    #2 reset_n = 0;
    #1;
    check("async_reset_rd", readdata0, 32'h0);
    check("async_reset_irq", {31'b0, irq0}, 32'h0);
    cycles(2);
    @(negedge clk) reset_n = 1;
    for (int i = 0; i < 6; i++) begin
      cycles(1);
      check($sformatf("arming_cap%0d", i), readdata0, 32'h0);
    end
    rd(0, 2'd1, 32'h0, "mask_after_reset");
    rd(0, 2'd0, 32'h07, "data_after_reset");
    @(negedge clk) in8 = 8'h87;
    cycles(3);
    rd(0, 2'd2, 32'h80, "cap_after_rearm");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ulight_fifo_status_capture.md
# ulight_fifo_status_capture

Parametrised Avalon-MM status input port for the uLight FIFO subsystem. It samples a vector of asynchronous status lines (FIFO empty/full flags, link state), synchronises them, detects edges, latches events in a write-1-to-clear capture register and raises a maskable interrupt. It sits on the HPS/Nios lightweight bus as a read/write slave and replaces the single-bit, read-only status ports.

## Interface
- WIDTH, 1: number of status inputs, 1..32.
- SYNC_STAGES, 2: synchroniser flip-flops per input, 1..4.
- EDGE_TYPE, 0: captured edge, 0 = rising, 1 = falling, 2 = any.
- IRQ_EN, 1: 1 = irq generated, 0 = irq tied low and mask register reads 0.

- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  2  word address of register.
- chipselect  in  1  slave select, qualifies writes.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- in_port  in  WIDTH  asynchronous status inputs.
- readdata  out  32  registered read data.
- irq  out  1  level interrupt, active high.

## Operation
- Register map (word offsets):
  - 0 DATA (RO): synchronised in_port.
  - 1 IRQMASK (RW): per-bit interrupt enable.
  - 2 EDGECAP (R/W1C): latched edge events.
  - 3 reads 0, writes ignored.
- Bits [31:WIDTH] of every register read 0; written values there are discarded.
- Write occurs when chipselect=1 and write_n=0 on a rising clk. Writes to offset 0 are ignored.
- Synchroniser: SYNC_STAGES-deep flop chain per bit; output is sync_q. A prev register holds sync_q delayed by one cycle.
- Edge detect per bit:
  - EDGE_TYPE 0: sync_q & ~prev.
  - EDGE_TYPE 1: ~sync_q & prev.
  - EDGE_TYPE 2: sync_q ^ prev.
- Arming: after reset, a counter runs SYNC_STAGES+1 cycles. Edge detection is suppressed until it saturates, so a static input level present at reset never produces a spurious event.
- EDGECAP bit set: edge detected while armed. Bit clear: write 1 to that bit at offset 2. Writing 0 has no effect.
- Simultaneous set and clear on the same bit in the same cycle: set wins, and the bit stays 1.
- irq = |(EDGECAP & IRQMASK), driven combinationally from the registers. Deasserts in the cycle after the clearing write or the masking write.

## Timing
- Reset values: readdata=0, irq=0, IRQMASK=0, EDGECAP=0, synchroniser=0, prev=0, arming counter=0.
- Read latency 1. readdata is loaded every clk from the current address, with no read strobe, and is valid on the edge after the address is presented.
- Input latency: in_port changes before edge k. sync_q reflects it after edge k+SYNC_STAGES-1. DATA is visible on readdata after edge k+SYNC_STAGES.
- Capture latency: the EDGECAP bit and irq assert after edge k+SYNC_STAGES.
- Pulses shorter than one clk period may be missed. Pulses of at least 2 clk periods are always captured.
- Multiple edges on one bit before clear collapse to a single 1. No counting.
- Reset asserted mid-operation: all state clears asynchronously. After release, the arming period restarts.
- Read and W1C write of EDGECAP in the same cycle: readdata shows the pre-clear value.

## Test plan
- Reset with in_port=all-ones, WIDTH=8, EDGE_TYPE=0. Wait 10 cycles, then read offset 2 -> 0x00000000 and irq=0. Read offset 0 -> 0x000000FF.
- WIDTH=8, SYNC_STAGES=2, IRQMASK=0x05. Drive in_port bit2 0->1 at edge k. EDGECAP=0x04 and irq=1 after edge k+2. Write 0x04 to offset 2 -> EDGECAP=0, and irq=0 the next cycle.
- Bit1 rises with IRQMASK=0x00. EDGECAP=0x02 and irq stays 0. Write IRQMASK=0x02 -> irq=1 the following cycle.
- EDGE_TYPE=2, toggle bit0 twice before clearing. EDGECAP bit0=1. Issue a W1C in the same cycle as a new edge -> bit0 remains 1.
- Write 0xFFFFFFFF to offset 1 with WIDTH=4. Read offset 1 -> 0x0000000F. Write to offset 0 and offset 3 -> no state change; offset 3 reads 0.
- Assert reset_n low mid-capture with EDGECAP=0x03. readdata, irq and all registers go to 0 immediately. After release, no event is captured for SYNC_STAGES+1 cycles.
